// File: rtl/traffic_phase_scheduler.sv
// Four-phase intersection sequencer: round-robin green grant with Green -> Yellow -> All-Red ordering.
// Optional emergency preemption for phase 0 is built when TLC_PREEMPT_EN is defined.
module traffic_phase_scheduler #(
    parameter int CNT_W    = 8,
    parameter int YELLOW_T = 3,
    parameter int CLEAR_T  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [3:0]       req,
    input  logic [CNT_W-1:0] green_min,
    input  logic [CNT_W-1:0] green_max,
`ifdef TLC_PREEMPT_EN
    input  logic             preempt,
`endif
    output logic [7:0]       lc_state,
    output logic [1:0]       phase,
    output logic [1:0]       fsm_state,
    output logic [CNT_W-1:0] cnt,
    output logic             phase_done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ALL_RED = 2'b01,
        S_GREEN   = 2'b10,
        S_YELLOW  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(CLEAR_T - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, state_nxt;
    logic [1:0]       last_grant, last_grant_nxt, phase_nxt;
    logic [1:0]       rr_winner, rr_idx;
    logic [CNT_W-1:0] gmin, gmax, gmin_m1, gmax_m1, cnt_nxt;
    logic [7:0]       lc_nxt;
    logic             other;
    logic             pre_cut, pre_hold, pre_grant;

    assign fsm_state = state;

    always_comb begin
        gmin    = (green_min == '0) ? CNT_W'(1) : green_min;
        gmax    = (green_max < gmin) ? gmin : green_max;
        gmin_m1 = gmin - CNT_W'(1);
        gmax_m1 = gmax - CNT_W'(1);
    end

    assign other = |(req & ~(4'b0001 << phase));

    // Walk offsets from farthest to nearest so the nearest requester after last_grant wins.
    always_comb begin
        rr_winner = 2'd0;
        rr_idx    = last_grant;
        for (int i = 4; i >= 1; i--) begin
            rr_idx = last_grant + 2'(i);
            if (req[rr_idx]) rr_winner = rr_idx;
        end
    end

`ifdef TLC_PREEMPT_EN
    logic pre_pend;

    assign pre_cut   = preempt && (phase != 2'd0);
    assign pre_hold  = preempt && (phase == 2'd0);
    assign pre_grant = preempt || pre_pend;

    // Remembers a preemption that cut a green short until the next arbitration serves it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_pend <= 1'b0;
        end else if (state == S_ALL_RED && state_nxt == S_GREEN) begin
            pre_pend <= 1'b0;
        end else if (state == S_GREEN && pre_cut) begin
            pre_pend <= 1'b1;
        end
    end
`else
    assign pre_cut   = 1'b0;
    assign pre_hold  = 1'b0;
    assign pre_grant = 1'b0;
`endif

    always_comb begin
        state_nxt      = state;
        phase_nxt      = phase;
        last_grant_nxt = last_grant;
        case (state)
            S_IDLE: begin
                if (en) state_nxt = S_ALL_RED;
            end
            S_ALL_RED: begin
                if (cnt == C_LAST) begin
                    if (!en) begin
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt      = S_GREEN;
                        phase_nxt      = pre_grant ? 2'd0 : rr_winner;
                        last_grant_nxt = phase_nxt;
                    end
                end
            end
            S_GREEN: begin
                if (!en || pre_cut) begin
                    state_nxt = S_YELLOW;
                end else if (!pre_hold && cnt >= gmin_m1 && other &&
                             (!req[phase] || cnt >= gmax_m1)) begin
                    state_nxt = S_YELLOW;
                end
            end
            S_YELLOW: begin
                if (cnt == Y_LAST) state_nxt = S_ALL_RED;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_nxt = cnt;
        if (state_nxt != state) begin
            cnt_nxt = '0;
        end else if (cnt != CNT_MAX) begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    // Non-granted fields read red (01); the granted field is patched to green or yellow.
    always_comb begin
        lc_nxt = 8'h00;
        case (state_nxt)
            S_IDLE:    lc_nxt = 8'h00;
            S_ALL_RED: lc_nxt = 8'h55;
            S_GREEN:   lc_nxt = 8'h55 | (8'h02 << {phase_nxt, 1'b0});
            S_YELLOW:  lc_nxt = (8'h55 & ~(8'h03 << {phase_nxt, 1'b0})) | (8'h02 << {phase_nxt, 1'b0});
            default:   lc_nxt = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            phase      <= 2'd0;
            last_grant <= 2'd3;
            cnt        <= '0;
            lc_state   <= 8'h00;
            phase_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            phase      <= phase_nxt;
            last_grant <= last_grant_nxt;
            cnt        <= cnt_nxt;
            lc_state   <= lc_nxt;
            phase_done <= (state == S_YELLOW) && (state_nxt == S_ALL_RED);
        end
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: directed scenarios, a behavioural intersection model
// checked every cycle, and hand-computed literal checks on both DUT and model.
module tb_traffic_phase_scheduler;

    localparam int CNT_W    = 8;
    localparam int YELLOW_T = 3;
    localparam int CLEAR_T  = 2;
    localparam int M_IDLE = 0, M_AR = 1, M_G = 2, M_Y = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic [3:0]       req = 4'b0000;
    logic [CNT_W-1:0] green_min = 8'd4;
    logic [CNT_W-1:0] green_max = 8'd10;
    logic             preempt = 1'b0;
    logic [7:0]       lc_state;
    logic [1:0]       phase;
    logic [1:0]       fsm_state;
    logic [CNT_W-1:0] cnt;
    logic             phase_done;

    int tests  = 0;
    int failed = 0;

    traffic_phase_scheduler #(.CNT_W(CNT_W), .YELLOW_T(YELLOW_T), .CLEAR_T(CLEAR_T)) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .req(req),
        .green_min(green_min),
        .green_max(green_max),
`ifdef TLC_PREEMPT_EN
        .preempt(preempt),
`endif
        .lc_state(lc_state),
        .phase(phase),
        .fsm_state(fsm_state),
        .cnt(cnt),
        .phase_done(phase_done)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int   m_st = M_IDLE, m_ph = 0, m_last = 3, m_cnt = 0;
    logic m_done = 1'b0;
    logic m_pend = 1'b0;

    function automatic logic [7:0] lc_of(input int st, input int ph);
        logic [7:0] v;
        v = 8'h00;
        if (st == M_AR) v = 8'h55;
        if (st == M_G || st == M_Y) begin
            for (int i = 0; i < 4; i++) begin
                if (i == ph) v[2*i +: 2] = (st == M_G) ? 2'b11 : 2'b10;
                else         v[2*i +: 2] = 2'b01;
            end
        end
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        int  ns, np, gmn, gmx, elapsed, c;
        bit  oth, found, pend_n;
        if (rst) begin
            m_st <= M_IDLE; m_ph <= 0; m_last <= 3; m_cnt <= 0; m_done <= 1'b0; m_pend <= 1'b0;
        end else begin
            ns = m_st; np = m_ph; pend_n = m_pend;
            gmn = (green_min == 0) ? 1 : int'(green_min);
            gmx = (int'(green_max) > gmn) ? int'(green_max) : gmn;
            elapsed = m_cnt + 1;
            oth = 0;
            for (int i = 0; i < 4; i++) if (i != m_ph && req[i]) oth = 1;
            if (m_st == M_IDLE) begin
                if (en) ns = M_AR;
            end else if (m_st == M_AR) begin
                if (elapsed == CLEAR_T) begin
                    if (!en) ns = M_IDLE;
                    else begin
                        ns = M_G; np = 0; found = 0;
                        for (int k = 1; k <= 4; k++) begin
                            c = (m_last + k) % 4;
                            if (!found && req[c]) begin np = c; found = 1; end
                        end
                        if (preempt || m_pend) np = 0;
                        pend_n = 0;
                        m_last <= np;
                    end
                end
            end else if (m_st == M_G) begin
                if (!en) ns = M_Y;
`ifdef TLC_PREEMPT_EN
                else if (preempt && m_ph != 0) begin ns = M_Y; pend_n = 1; end
                else if (preempt && m_ph == 0) ns = M_G;
`endif
                else if (elapsed >= gmn && oth && (!req[m_ph] || elapsed >= gmx)) ns = M_Y;
            end else begin
                if (elapsed == YELLOW_T) ns = M_AR;
            end
            m_done <= (m_st == M_Y && ns == M_AR);
            m_cnt  <= (ns != m_st) ? 0 : m_cnt + 1;
            m_st   <= ns;
            m_ph   <= np;
            m_pend <= pend_n;
        end
    end

    function automatic logic [7:0] exp_cnt();
        return (m_cnt > 255) ? 8'hFF : 8'(m_cnt);
    endfunction

    // ---------------- scoreboard: every-cycle compare ----------------
    always @(negedge clk) begin
        if (!rst) begin
            tests++;
            if (lc_state !== lc_of(m_st, m_ph) || fsm_state !== 2'(m_st) || phase !== 2'(m_ph) ||
                cnt !== exp_cnt() || phase_done !== m_done) begin
                failed++;
                $display("FAIL cycle_compare t=%0t got lc=%h st=%0d ph=%0d cnt=%0d done=%0b want lc=%h st=%0d ph=%0d cnt=%0d done=%0b",
                         $time, lc_state, fsm_state, phase, cnt, phase_done,
                         lc_of(m_st, m_ph), m_st, m_ph, exp_cnt(), m_done);
            end
        end
    end

    int done_cnt = 0;
    always @(posedge clk) if (!rst && phase_done) done_cnt <= done_cnt + 1;

    // ---------------- driver / check tasks ----------------
    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic wait_state(input int st, input int ph, input int budget, input string nm);
        int n = 0;
        while (!(int'(fsm_state) == st && int'(phase) == ph) && n < budget) begin
            @(negedge clk); n++;
        end
        tests++;
        if (n >= budget) begin
            failed++;
            $display("FAIL %s: timeout after %0d cycles, got state=%0d phase=%0d, want state=%0d phase=%0d",
                     nm, n, fsm_state, phase, st, ph);
        end
    endtask

    task automatic count_run(input int st, output int n);
        n = 0;
        while (int'(fsm_state) == st && n < 1000) begin
            n++; @(negedge clk);
        end
    endtask

    // ---------------- stimulus ----------------
    int n, m, base;
    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        repeat (3) @(negedge clk);
        check("reset_lc", lc_state, 8'h00);
        check("reset_phase", phase, 0);
        check("reset_fsm", fsm_state, 0);
        check("reset_cnt", cnt, 0);
        check("reset_done", phase_done, 0);
        check("model_reset_lc", lc_of(m_st, m_ph), 8'h00);

        // Startup with no requests: 2 cycles all-red then default phase 0.
        rst = 1'b0; en = 1'b1;
        @(negedge clk);
        check("allred_fsm", fsm_state, 1);
        check("allred_lc", lc_state, 8'h55);
        @(negedge clk);
        check("allred_cnt1", cnt, 1);
        @(negedge clk);
        check("green0_lc", lc_state, 8'h57);
        check("model_green0_lc", lc_of(m_st, m_ph), 8'h57);
        check("green0_phase", phase, 0);
        repeat (50) @(negedge clk);
        check("green0_held_lc", lc_state, 8'h57);

        // Two waiting phases, req[1] held: max-green limit of 10 cycles.
        req = 4'b0110;
        wait_state(M_G, 1, 20, "reach_green1");
        check("green1_lc", lc_state, 8'h5D);
        count_run(M_G, n);
        check("green1_len_gmax", n, 10);
        check("yellow1_lc", lc_state, 8'h59);
        count_run(M_Y, n);
        check("yellow_len", n, 3);
        check("done_pulse", phase_done, 1);
        count_run(M_AR, n);
        check("allred_len", n, 2);
        check("green2_phase", phase, 2);
        check("green2_lc", lc_state, 8'h75);

        // Phase 1 drops its request at cnt=1 while phase 3 waits: gmin of 4 still holds.
        req = 4'b0010;
        wait_state(M_G, 1, 30, "reach_green1_again");
        req = 4'b1010;
        @(negedge clk);
        req = 4'b1000;
        count_run(M_G, m);
        check("green1_len_gmin", m + 1, 4);
        wait_state(M_G, 3, 20, "reach_green3");

        // Zero timing values, all requests: one green cycle per phase in order.
        green_min = 8'd0; green_max = 8'd0; req = 4'b1111;
        count_run(M_G, n);
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (int'(fsm_state) != M_G && n < 50) begin @(negedge clk); n++; end
            check("rr_wait_bound", int'(n < 50), 1);
            check("rr_order", phase, exp_order[k]);
            if (k == 0) base = done_cnt;
            if (k < 4) begin
                count_run(M_G, n);
                check("rr_green_len", n, 1);
            end
        end
        check("rr_done_pulses", done_cnt - base, 4);

        // Disable at green cnt=0: yellow next cycle regardless of gmin, then idle.
        en = 1'b0; green_min = 8'd20; green_max = 8'd40;
        @(negedge clk);
        check("disable_yellow", fsm_state, 3);
        count_run(M_Y, n);
        check("disable_yellow_len", n, 3);
        count_run(M_AR, n);
        check("disable_allred_len", n, 2);
        check("idle_fsm", fsm_state, 0);
        check("idle_lc", lc_state, 8'h00);

        // Asynchronous reset in the middle of yellow.
        en = 1'b1; req = 4'b0000;
        wait_state(M_G, 0, 20, "reenable_green0");
        req = 4'b0100;
        wait_state(M_Y, 0, 100, "reach_yellow0");
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_rst_lc", lc_state, 8'h00);
        check("async_rst_fsm", fsm_state, 0);
        check("async_rst_cnt", cnt, 0);
        check("async_rst_phase", phase, 0);
        @(negedge clk);
        green_min = 8'd4; green_max = 8'd10; req = 4'b0100;
        rst = 1'b0;
        wait_state(M_G, 2, 20, "post_rst_green2");

`ifdef TLC_PREEMPT_EN
        preempt = 1'b1; req = 4'b1110;
        @(negedge clk);
        check("preempt_yellow", fsm_state, 3);
        wait_state(M_G, 0, 20, "preempt_green0");
        check("preempt_lc", lc_state, 8'h57);
        repeat (30) @(negedge clk);
        check("preempt_hold_fsm", fsm_state, 2);
        check("preempt_hold_phase", phase, 0);
        preempt = 1'b0;
        wait_state(M_G, 1, 40, "after_preempt_green1");
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
